// File: rtl/axis_bcd_pkg.sv
// Shared types, constants and digit helpers for the scheduled binary-to-BCD converter.
package axis_bcd_pkg;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam int unsigned ADD3_THRESH = 5;
    localparam int unsigned MAX_DIGITS  = 16;
    localparam int unsigned MAX_BCD_W   = BCD_DIGIT_W * MAX_DIGITS;

    // Double-dabble correction: every digit >= 5 gets +3 before the next shift.
    function automatic logic [MAX_BCD_W-1:0] add3_digits(input logic [MAX_BCD_W-1:0] bcd);
        logic [MAX_BCD_W-1:0]   res;
        logic [BCD_DIGIT_W-1:0] dig;
        res = '0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            dig = bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W];
            res[i*BCD_DIGIT_W +: BCD_DIGIT_W] =
                (dig >= BCD_DIGIT_W'(ADD3_THRESH)) ? dig + BCD_DIGIT_W'(3) : dig;
        end
        return res;
    endfunction

    function automatic longint unsigned pow10(input int unsigned d);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < d; i++) p = p * 64'd10;
        return p;
    endfunction

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_bcd_sched_core.sv
// Iterative shift-add-3 binary-to-BCD core, one operand bit per step.
module bcd_iter_core
    import axis_bcd_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned D = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic                       step,
    input  logic [W-1:0]               operand,
    output logic                       done,
    output logic [BCD_DIGIT_W*D-1:0]   bcd
);

    localparam int unsigned BW = BCD_DIGIT_W * D;
    localparam int unsigned SW = BW + W;
    localparam int unsigned CW = $clog2(W + 1);

    logic [SW-1:0] sr;
    logic [SW-1:0] pre;
    logic [CW-1:0] cnt;

    // Digits are corrected on the pre-shift value, then the whole register shifts.
    always_comb begin
        pre = {BW'(add3_digits(MAX_BCD_W'(sr[SW-1:W]))), sr[W-1:0]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= SW'(operand);
            cnt <= '0;
        end else if (step && !done) begin
            sr  <= {pre[SW-2:0], 1'b0};
            cnt <= cnt + CW'(1);
        end
    end

    assign done = (cnt == CW'(W));
    assign bcd  = sr[SW-1:W];

endmodule

// File: rtl/axis_bcd_sched.sv
// Round-robin scheduler sharing one iterative BCD converter among N requesters.
// Optional two's-complement operands when AXIS_BCD_SIGNED_EN is defined.
module axis_bcd_sched
    import axis_bcd_pkg::*;
#(
    parameter int unsigned N = 3,
    parameter int unsigned W = 8,
    parameter int unsigned D = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N-1:0]                req_valid,
    input  logic [N*W-1:0]              req_data,
    output logic [N-1:0]                req_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BCD_DIGIT_W*D-1:0]    out_bcd,
    output logic [id_width(N)-1:0]      out_id,
    output logic                        out_neg
);

    localparam int unsigned IW = id_width(N);
    localparam int unsigned BW = BCD_DIGIT_W * D;

    if (N < 1 || N > 8) begin : g_bad_n
        $error("axis_bcd_sched: N must be 1..8");
    end
    if (D > MAX_DIGITS || pow10(D) < (64'd1 << W)) begin : g_bad_d
        $error("axis_bcd_sched: D digits cannot hold 2^W-1");
    end

    state_t          state, state_next;
    logic [IW-1:0]   rr, grant_id, id_q;
    logic            grant_any, load, step, core_done, neg_q, neg_in;
    logic [W-1:0]    sel, mag;
    logic [BW-1:0]   core_bcd;
    int unsigned     pos;

    // First valid requester at/after the rr pointer, wrapping; only offered in IDLE.
    always_comb begin
        req_ready = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        pos       = 0;
        if (state == IDLE) begin
            for (int unsigned i = 0; i < N; i++) begin
                pos = 32'(rr) + i;
                if (pos >= N) pos = pos - N;
                if (!grant_any && req_valid[IW'(pos)]) begin
                    grant_any = 1'b1;
                    grant_id  = IW'(pos);
                end
            end
            if (grant_any) req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        sel = req_data[32'(grant_id)*W +: W];
`ifdef AXIS_BCD_SIGNED_EN
        neg_in = sel[W-1];
        mag    = neg_in ? (~sel) + W'(1) : sel;
`else
        neg_in = 1'b0;
        mag    = sel;
`endif
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    load       = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                step = 1'b1;
                if (core_done) state_next = DONE;
            end
            DONE: begin
                if (out_valid && out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr        <= '0;
            id_q      <= '0;
            neg_q     <= 1'b0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_id    <= '0;
            out_neg   <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                rr    <= (grant_id == IW'(N - 1)) ? '0 : grant_id + IW'(1);
                id_q  <= grant_id;
                neg_q <= neg_in;
            end
            // Result registers hold until the next conversion completes.
            if (state == CONV && core_done) begin
                out_valid <= 1'b1;
                out_bcd   <= core_bcd;
                out_id    <= id_q;
                out_neg   <= neg_q;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    bcd_iter_core #(
        .W (W),
        .D (D)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .step    (step),
        .operand (mag),
        .done    (core_done),
        .bcd     (core_bcd)
    );

endmodule
